frame_buffer_arbiter: RTL and testbench

//  Owns the single-port image RAM shared by the image filter (writer/reader) and the VGA interface (reader).

---
 rtl/fb_pkg.sv | 12 +
 rtl/fb_swap_ctrl.sv | 39 +++
 rtl/frame_buffer_arbiter.sv | 101 ++++++++++
 tb/tb_frame_buffer_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and default sizes for the frame buffer arbiter and its swap controller.
package fb_pkg;

  localparam int ADDR_W_DEF       = 19;
  localparam int DATA_W_DEF       = 8;
  localparam int STARVE_LIMIT_DEF = 1024;

  typedef enum logic {IDLE, PENDING} swap_state_t;

  typedef enum logic {SRC_VGA, SRC_FLT} src_t;

endpackage

// File: rtl/fb_swap_ctrl.sv
// Ping-pong bank swap controller: latches the filter's frame_done and flips the
// VGA front bank on the next frame_start.
module fb_swap_ctrl
  import fb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic frame_done,
  input  logic frame_start,
  output logic swap_pending,
  output logic front_bank
);

  swap_state_t state;

  // A frame_start in the same cycle as frame_done is too early to swap on, so IDLE ignores it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      front_bank <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_done) state <= PENDING;
        end
        PENDING: begin
          if (frame_start) begin
            state      <= IDLE;
            front_bank <= ~front_bank;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign swap_pending = (state == PENDING);

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Single-port image RAM arbiter: VGA has priority over the filter, each side sees
// its own bank of a ping-pong pair, and read data returns via a 2-stage tag pipeline.
module frame_buffer_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  input  logic              frame_start,
  input  logic              flt_req,
  input  logic              flt_we,
  input  logic [ADDR_W-1:0] flt_addr,
  input  logic [DATA_W-1:0] flt_wdata,
  output logic              flt_gnt,
  output logic [DATA_W-1:0] flt_rdata,
  output logic              flt_rvalid,
  input  logic              frame_done,
  output logic              swap_pending,
  output logic              front_bank,
  output logic              flt_starved,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W:0]   ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic       tag1_valid, tag2_valid;
  src_t       tag1_src, tag2_src;
  logic [CNT_W-1:0] starve_cnt;
  logic       vga_denial;

  fb_swap_ctrl u_swap (
    .clk          (clk),
    .reset        (reset),
    .frame_done   (frame_done),
    .frame_start  (frame_start),
    .swap_pending (swap_pending),
    .front_bank   (front_bank)
  );

  assign flt_gnt    = flt_req & ~vga_req & ~swap_pending;
  assign vga_denial = flt_req & ~flt_gnt & ~swap_pending;

  // Command registers plus the read tag pipeline; the tag rides alongside the RAM's 1-cycle latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      tag1_valid <= 1'b0;
      tag1_src   <= SRC_VGA;
      tag2_valid <= 1'b0;
      tag2_src   <= SRC_VGA;
    end else begin
      ram_en <= vga_req | flt_gnt;
      ram_we <= flt_gnt & flt_we;
      if (vga_req) begin
        ram_addr <= {front_bank, vga_addr};
      end else if (flt_gnt) begin
        ram_addr  <= {~front_bank, flt_addr};
        ram_wdata <= flt_wdata;
      end
      tag1_valid <= vga_req | (flt_gnt & ~flt_we);
      tag1_src   <= vga_req ? SRC_VGA : SRC_FLT;
      tag2_valid <= tag1_valid;
      tag2_src   <= tag1_src;
    end
  end

  // Only VGA-caused denials count; a pending swap blocking the filter is expected, not starvation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt  <= '0;
      flt_starved <= 1'b0;
    end else begin
      if (vga_denial) begin
        if (starve_cnt != CNT_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
        if (starve_cnt >= CNT_W'(STARVE_LIMIT - 1)) flt_starved <= 1'b1;
      end else if (flt_gnt || !flt_req) begin
        starve_cnt <= '0;
      end
    end
  end

  assign vga_valid  = tag2_valid & (tag2_src == SRC_VGA);
  assign flt_rvalid = tag2_valid & (tag2_src == SRC_FLT);
  assign vga_data   = vga_valid  ? ram_rdata : '0;
  assign flt_rdata  = flt_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Scoreboard bench for frame_buffer_arbiter: directed vectors push expected read
// returns; a negedge monitor pops and compares every valid pulse.
module tb_frame_buffer_arbiter;
  import fb_pkg::*;

  localparam int AW = 19;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_data;
  logic          vga_valid;
  logic          frame_start;
  logic          flt_req;
  logic          flt_we;
  logic [AW-1:0] flt_addr;
  logic [DW-1:0] flt_wdata;
  logic          flt_gnt;
  logic [DW-1:0] flt_rdata;
  logic          flt_rvalid;
  logic          frame_done;
  logic          swap_pending;
  logic          front_bank;
  logic          flt_starved;
  logic          ram_en;
  logic          ram_we;
  logic [AW:0]   ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  typedef struct {
    src_t          src;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_exp;
  int   errors = 0;
  int   checks = 0;

  logic [DW-1:0] mem [int];

  frame_buffer_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .vga_req      (vga_req),
    .vga_addr     (vga_addr),
    .vga_data     (vga_data),
    .vga_valid    (vga_valid),
    .frame_start  (frame_start),
    .flt_req      (flt_req),
    .flt_we       (flt_we),
    .flt_addr     (flt_addr),
    .flt_wdata    (flt_wdata),
    .flt_gnt      (flt_gnt),
    .flt_rdata    (flt_rdata),
    .flt_rvalid   (flt_rvalid),
    .frame_done   (frame_done),
    .swap_pending (swap_pending),
    .front_bank   (front_bank),
    .flt_starved  (flt_starved),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  always #20 clk = ~clk;

  // Synchronous single-port RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[int'(ram_addr)] = ram_wdata;
      else ram_rdata <= mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : '0;
    end
  end

  always @(negedge clk) begin
    if (vga_valid || flt_rvalid) begin
      checks++;
      if (vga_valid && flt_rvalid) begin
        errors++;
        $display("[TB] FAIL dual_valid: got vga_valid=1 flt_rvalid=1 expected only one");
      end else if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_valid: got vga=%0b flt=%0b data 0x%0h expected no pulse",
                 vga_valid, flt_rvalid, vga_valid ? vga_data : flt_rdata);
      end else begin
        mon_exp = sb.pop_front();
        if ((vga_valid ? SRC_VGA : SRC_FLT) != mon_exp.src ||
            (vga_valid ? vga_data : flt_rdata) != mon_exp.data) begin
          errors++;
          $display("[TB] FAIL read_return: got src=%0d data=0x%0h expected src=%0d data=0x%0h",
                   vga_valid ? SRC_VGA : SRC_FLT, vga_valid ? vga_data : flt_rdata,
                   mon_exp.src, mon_exp.data);
        end
      end
    end
  end

  task automatic applyStimulus(input logic vr, input logic [AW-1:0] va, input logic fr,
                               input logic fw, input logic [AW-1:0] fa, input logic [DW-1:0] fd,
                               input logic done, input logic start);
    vga_req     = vr;
    vga_addr    = va;
    flt_req     = fr;
    flt_we      = fw;
    flt_addr    = fa;
    flt_wdata   = fd;
    frame_done  = done;
    frame_start = start;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic push(input src_t s, input logic [DW-1:0] d);
    exp_t e;
    e.src  = s;
    e.data = d;
    sb.push_back(e);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mem[int'({1'b0, 19'd5})] = 8'h37;
    reset = 1'b1;
    idle();
    cycle();
    cycle();
    checkOutput("reset_ram_en", ram_en, 0);
    checkOutput("reset_ram_addr", ram_addr, 0);
    checkOutput("reset_front_bank", front_bank, 0);
    checkOutput("reset_swap_pending", swap_pending, 0);
    checkOutput("reset_starved", flt_starved, 0);
    checkOutput("reset_valids", {vga_valid, flt_rvalid}, 0);
    reset = 1'b0;
    cycle();

    $display("[TB] VGA priority read");
    applyStimulus(1'b1, 19'd5, 1'b1, 1'b0, 19'd7, '0, 1'b0, 1'b0);
    #1;
    checkOutput("t1_flt_gnt", flt_gnt, 0);
    push(SRC_VGA, 8'h37);
    cycle();
    idle();
    checkOutput("t1_ram_en", ram_en, 1);
    checkOutput("t1_ram_we", ram_we, 0);
    checkOutput("t1_ram_addr", ram_addr, {1'b0, 19'd5});
    checkOutput("t1_early_valid", vga_valid, 0);
    cycle();
    checkOutput("t1_vga_valid_lat2", vga_valid, 1);
    checkOutput("t1_vga_data", vga_data, 8'h37);
    cycle();

    $display("[TB] Filter write and readback");
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 19'd10, 8'hA5, 1'b0, 1'b0);
    #1;
    checkOutput("t2_flt_gnt", flt_gnt, 1);
    cycle();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 19'd10, '0, 1'b0, 1'b0);
    checkOutput("t2_ram_we", ram_we, 1);
    checkOutput("t2_ram_addr", ram_addr, {1'b1, 19'd10});
    checkOutput("t2_ram_wdata", ram_wdata, 8'hA5);
    push(SRC_FLT, 8'hA5);
    cycle();
    idle();
    checkOutput("t2_read_ram_addr", ram_addr, {1'b1, 19'd10});
    repeat (3) cycle();

    $display("[TB] Swap pending blocks filter");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    cycle();
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 19'd20, 8'h11, 1'b0, 1'b0);
    checkOutput("t3_swap_pending", swap_pending, 1);
    for (int i = 0; i < 100; i++) begin
      if (i == 99) frame_start = 1'b1;
      #1;
      checkOutput("t3_flt_gnt_blocked", flt_gnt, 0);
      checkOutput("t3_pending_held", swap_pending, 1);
      cycle();
      checkOutput("t3_no_access", ram_en, 0);
    end
    idle();
    checkOutput("t3_front_bank", front_bank, 1);
    checkOutput("t3_swap_cleared", swap_pending, 0);
    checkOutput("t3_no_starve", flt_starved, 0);
    applyStimulus(1'b1, 19'd10, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    push(SRC_VGA, 8'hA5);
    cycle();
    idle();
    checkOutput("t3_vga_bank_addr", ram_addr, {1'b1, 19'd10});
    repeat (3) cycle();

    $display("[TB] Coincident frame_done and frame_start");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    cycle();
    checkOutput("t4_idle_start_noop", {front_bank, swap_pending}, 2'b10);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    cycle();
    idle();
    checkOutput("t4_no_toggle", front_bank, 1);
    checkOutput("t4_pending", swap_pending, 1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    cycle();
    idle();
    checkOutput("t4_done_ignored", {front_bank, swap_pending}, 2'b11);
    repeat (3) cycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    cycle();
    idle();
    checkOutput("t4_toggle", front_bank, 0);
    checkOutput("t4_pending_clear", swap_pending, 0);

    $display("[TB] Starvation under continuous VGA reads");
    applyStimulus(1'b1, 19'd5, 1'b1, 1'b0, 19'd3, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      push(SRC_VGA, 8'h37);
      cycle();
      checkOutput("t5_starved_step", flt_starved, (i == 8) ? 1 : 0);
    end
    idle();
    repeat (4) cycle();
    checkOutput("t5_starved_sticky", flt_starved, 1);

    $display("[TB] Reset mid-read");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    cycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    cycle();
    checkOutput("t6_pre_state", {front_bank, swap_pending}, 2'b11);
    applyStimulus(1'b1, 19'd5, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    idle();
    checkOutput("t6_grant_issued", ram_en, 1);
    #5;
    reset = 1'b1;
    #1;
    checkOutput("t6_ram_en_async", ram_en, 0);
    checkOutput("t6_front_bank", front_bank, 0);
    checkOutput("t6_pending_lost", swap_pending, 0);
    checkOutput("t6_starved_cleared", flt_starved, 0);
    cycle();
    checkOutput("t6_no_vga_valid", vga_valid, 0);
    reset = 1'b0;
    repeat (4) cycle();

    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
